// File: rtl/binary_morph3x3.sv
// Streaming 3x3 binary erosion/dilation over a raster-order 0/255 pixel stream.
// Two 1-bit line buffers feed a 3-column window; a WIDTH+1 cycle flush drains each frame.
module binary_morph3x3 #(
  parameter int HEIGHT = 768,
  parameter int WIDTH  = 512,
  parameter bit MODE   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_pix,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_pix,
  output logic       out_last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = $clog2(HEIGHT + 2);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic          PAD      = ~MODE;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_next;

  // icol/irow address the incoming pixel; ocol/orow track the output centre pixel.
  logic [CW-1:0]    icol, ocol;
  logic [RW-1:0]    irow, orow;
  logic [WIDTH-1:0] lb_prev, lb_prev2;
  logic [2:0]       win_left, win_mid, new_col;
  logic [8:0]       taps, tap_mask;
  logic [2:0]       row_ok, col_ok;
  logic             bin, accept, step, emit, last_out, result;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL: begin
        if (accept && irow == ROW_ONE && icol == '0) state_next = RUN;
      end
      RUN: begin
        if (accept && irow == ROW_LAST && icol == COL_LAST) state_next = FLUSH;
      end
      FLUSH: begin
        if (last_out) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_comb begin
    in_ready = (state != FLUSH);
  end

  assign accept   = in_valid && in_ready;
  assign step     = accept || (state == FLUSH);
  assign emit     = (accept && state == RUN) || (state == FLUSH);
  assign last_out = (orow == ROW_LAST) && (ocol == COL_LAST);
  assign bin      = (state == FLUSH) ? PAD : (in_pix != 8'd0);

  // Column vector is {row-2, row-1, row} relative to the incoming pixel row.
  assign new_col  = {lb_prev2[icol], lb_prev[icol], bin};
  assign taps     = {win_left, win_mid, new_col};

  // Off-frame taps are dropped from the reduction, which is the same as padding
  // them with the neutral value; the column masks also stop row wrap-around.
  assign row_ok   = {orow != '0, 1'b1, orow != ROW_LAST};
  assign col_ok   = {ocol != '0, 1'b1, ocol != COL_LAST};
  assign tap_mask = {{3{col_ok[2]}} & row_ok, {3{col_ok[1]}} & row_ok, {3{col_ok[0]}} & row_ok};
  assign result   = MODE ? |(taps & tap_mask) : &(taps | ~tap_mask);

  always_ff @(posedge clk) begin
    if (accept) begin
      lb_prev2[icol] <= lb_prev[icol];
      lb_prev[icol]  <= bin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      icol      <= '0;
      irow      <= '0;
      ocol      <= '0;
      orow      <= '0;
      win_left  <= '0;
      win_mid   <= '0;
      out_valid <= 1'b0;
      out_pix   <= 8'h00;
      out_last  <= 1'b0;
    end else begin
      out_valid <= emit;
      out_last  <= emit && last_out;
      out_pix   <= (emit && result) ? 8'hFF : 8'h00;
      if (step) begin
        win_left <= win_mid;
        win_mid  <= new_col;
        if (icol == COL_LAST) begin
          icol <= '0;
          irow <= irow + ROW_ONE;
        end else begin
          icol <= icol + COL_ONE;
        end
      end
      if (emit) begin
        if (last_out) begin
          ocol <= '0;
          orow <= '0;
          icol <= '0;
          irow <= '0;
        end else if (ocol == COL_LAST) begin
          ocol <= '0;
          orow <= orow + ROW_ONE;
        end else begin
          ocol <= ocol + COL_ONE;
        end
      end
    end
  end

endmodule

// File: doc/binary_morph3x3.md
# binary_morph3x3

Streaming 3x3 binary morphology (erosion or dilation) on the thresholded pixel stream. It sits directly downstream of the threshold stage and consumes its 0/255 pixels in raster order. It cleans isolated speckle (erosion) or fills pinholes (dilation), then forwards a 0/255 stream of the same frame size to the image writer. Two 1-bit line buffers plus a 3x3 window register give one output pixel per accepted input pixel, followed by a short flush at frame end.

## Interface
- HEIGHT, 768, frame rows
- WIDTH, 512, frame columns (≥3)
- MODE, 0, 0 = erosion, 1 = dilation
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_pix valid this cycle
- in_pix  input  8  threshold output; any nonzero value = foreground (1)
- in_ready  output  1  block accepts a pixel when in_valid && in_ready
- out_valid  output  1  out_pix/out_last valid this cycle
- out_pix  output  8  result pixel, 255 (foreground) or 0
- out_last  output  1  high with the final pixel (index HEIGHT*WIDTH-1) of each frame

## Operation
- N = HEIGHT*WIDTH. Accepted pixels are raster-indexed k = 0..N-1 by internal row/col counters. There is no frame-start input; the frame boundary is the count reaching N.
- Input is binarised as b = (in_pix != 0). Line buffers hold the previous two rows of b.
- Output pixel at index p (row r, col c) is computed over the 3x3 neighbourhood centred at (r,c).
  - Erosion: AND of the 9 taps. Dilation: OR of the 9 taps.
  - Taps outside the frame (row -1, row HEIGHT, col -1, col WIDTH) take the pad value: 1 for erosion, 0 for dilation. Borders are therefore never eroded or dilated by off-frame padding.
  - Column wrap-around in the window is masked to pad; it must never pull pixels from the adjacent row.
- Output is 255 if the result is 1, else 0.
- State machine:
  - FILL: after reset or a completed frame. Accepts k = 0..WIDTH; no output yet. Go to RUN once index WIDTH is accepted.
  - RUN: each accepted index k emits output index k-WIDTH-1. When k = N-1 is accepted, go to FLUSH.
  - FLUSH: in_ready = 0. Emits the remaining WIDTH+1 outputs (indices N-WIDTH-1..N-1), one per cycle on consecutive cycles; bottom-row taps are pad. After the output with out_last, clear the counters and go to FILL with in_ready = 1.
- Gaps on in_valid stall the pipeline; no output is generated without an accepted input, except in FLUSH.
- Reset, including mid-frame: on the clock edge with rst high, discard all partial state. Line buffer contents need not be cleared because they are fully masked in FILL. The next accepted pixel is index 0 of a new frame.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_pix = 0, out_last = 0, state = FILL, counters = 0.
- Latency: an accepted input at index k ≥ WIDTH+1 produces out_valid on the next rising edge, carrying index k-WIDTH-1.
- FLUSH lasts exactly WIDTH+1 cycles. in_ready is low for those cycles and returns high on the cycle after out_last.
- out_last is a single-cycle pulse, once per frame.
- Every frame yields exactly N outputs.
- out_valid and out_pix are registered outputs. in_ready is a registered function of state.
- No backpressure from downstream: the consumer must accept every out_valid cycle.

## Test plan
- HEIGHT=4, WIDTH=4, MODE=0, all inputs 255 with continuous in_valid -> 16 outputs all 255; out_last only on the 16th; in_ready low for exactly 5 cycles.
- Same size, MODE=1, single 255 at (1,1), rest 0 -> 255 at rows 0-2 × cols 0-2 (9 pixels), all others 0.
- Same single-pixel frame, MODE=0 -> all 16 outputs 0. Then a frame of 255 with only (3,3)=0 -> outputs 0 at (2,2),(2,3),(3,2),(3,3), others 255; checks no column wrap.
- Frame from scenario 2 with in_valid toggling 1/0 every cycle -> identical output sequence; output count equals accepted count after fill; flush is still 5 contiguous cycles.
- Feed 7 pixels, assert rst for 1 cycle, then send a full all-0 MODE=1 frame -> exactly 16 outputs, all 0, no output derived from the aborted pixels.
- Two back-to-back frames with no idle cycles: frame A all in_pix=1, frame B all 0, MODE=1 -> A outputs all 255 and B outputs all 0, with no bleed across the boundary; out_last pulses twice.
